data_req_issuer: RTL and testbench

Store/load request issuer on the EXE→data-SRAM side of the pipeline; the write-direction counterpart of the MEM-stage load extractor. It formats each memory instruction into an aligned sram-like transaction: address, size, byte strobes and byte-lane-replicated write data. It then drives the request with a req/addr_ok handshake and counts outstanding transactions until data_ok. On flush, it marks in-flight responses for discard so MEM never consumes stale read data.

---
 rtl/data_req_issuer_if.sv | 34 +++
 rtl/data_req_issuer.sv | 189 ++++++++++++++++++
 tb/tb_data_req_issuer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_req_issuer_if.sv
// data_req_issuer_if: sram-like data request/response bus between the issuer
// (master) and the data SRAM side (slave).
interface data_req_issuer_if;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;

    modport master (
        output data_sram_req,
        output data_sram_wr,
        output data_sram_size,
        output data_sram_wstrb,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_addr_ok,
        input  data_sram_data_ok
    );

    modport slave (
        input  data_sram_req,
        input  data_sram_wr,
        input  data_sram_size,
        input  data_sram_wstrb,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_addr_ok,
        output data_sram_data_ok
    );
endinterface

// File: rtl/data_req_issuer.sv
// data_req_issuer: formats EXE memory ops into aligned sram-like requests,
// drives the req/addr_ok handshake, tracks outstanding transactions and
// discards responses that belong to ops flushed from the pipeline.
// Optional feature: define UNALIGNED_STORE_EN to issue swl/swr; without it
// those ops are accepted and silently dropped.
module data_req_issuer #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     es_req_valid,
    output logic                     es_req_ready,
    input  logic [11:0]              es_mem_op,
    input  logic [31:0]              es_addr,
    input  logic [31:0]              es_rt_data,
    input  logic                     flush,
    data_req_issuer_if.master        sram,
    output logic                     ms_rsp_valid,
    output logic [2:0]               outstanding
);

    // One-hot op bit positions
    localparam int unsigned OpLb  = 11;
    localparam int unsigned OpLbu = 10;
    localparam int unsigned OpLh  = 9;
    localparam int unsigned OpLhu = 8;
    localparam int unsigned OpSb  = 4;
    localparam int unsigned OpSh  = 3;
    localparam int unsigned OpSw  = 2;
    localparam int unsigned OpSwl = 1;
    localparam int unsigned OpSwr = 0;

    localparam logic [2:0] MaxOut = 3'(MAX_OUTSTANDING);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e      state_q, state_d;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  out_q, out_d;
    logic [3:0]  discard_q, discard_d;

    logic [1:0]  a_lo;
    logic        is_byte, is_half;
    logic        fmt_bus, fmt_wr;
    logic [1:0]  fmt_size;
    logic [3:0]  fmt_wstrb;
    logic [31:0] fmt_addr, fmt_wdata;
    logic        load_req;
    logic        addr_hs, rsp_hs;

    assign a_lo    = es_addr[1:0];
    assign is_byte = es_mem_op[OpLb] | es_mem_op[OpLbu] | es_mem_op[OpSb];
    assign is_half = es_mem_op[OpLh] | es_mem_op[OpLhu] | es_mem_op[OpSh];

`ifdef UNALIGNED_STORE_EN
    assign fmt_bus = |es_mem_op;
    assign fmt_wr  = |es_mem_op[4:0];
`else
    // swl/swr are consumed without touching the bus
    assign fmt_bus = (|es_mem_op) & ~(es_mem_op[OpSwl] | es_mem_op[OpSwr]);
    assign fmt_wr  = |es_mem_op[4:2];
`endif

    // Format size, aligned address, strobes and lane-replicated write data
    always_comb begin
        fmt_size  = 2'd2;
        fmt_addr  = {es_addr[31:2], 2'b00};
        fmt_wstrb = 4'b0000;
        fmt_wdata = 32'h0;
        if (is_byte) begin
            fmt_size = 2'd0;
            fmt_addr = es_addr;
        end else if (is_half) begin
            fmt_size = 2'd1;
            fmt_addr = es_addr;
        end
        if (es_mem_op[OpSb]) begin
            fmt_wstrb = 4'b0001 << a_lo;
            fmt_wdata = {4{es_rt_data[7:0]}};
        end
        if (es_mem_op[OpSh]) begin
            fmt_wstrb = a_lo[1] ? 4'b1100 : 4'b0011;
            fmt_wdata = {2{es_rt_data[15:0]}};
        end
        if (es_mem_op[OpSw]) begin
            fmt_wstrb = 4'b1111;
            fmt_wdata = es_rt_data;
        end
`ifdef UNALIGNED_STORE_EN
        if (es_mem_op[OpSwl]) begin
            case (a_lo)
                2'd0: begin fmt_wstrb = 4'b0001; fmt_wdata = {24'b0, es_rt_data[31:24]}; end
                2'd1: begin fmt_wstrb = 4'b0011; fmt_wdata = {16'b0, es_rt_data[31:16]}; end
                2'd2: begin fmt_wstrb = 4'b0111; fmt_wdata = {8'b0, es_rt_data[31:8]}; end
                default: begin fmt_wstrb = 4'b1111; fmt_wdata = es_rt_data; end
            endcase
        end
        if (es_mem_op[OpSwr]) begin
            case (a_lo)
                2'd0: begin fmt_wstrb = 4'b1111; fmt_wdata = es_rt_data; end
                2'd1: begin fmt_wstrb = 4'b1110; fmt_wdata = {es_rt_data[23:0], 8'b0}; end
                2'd2: begin fmt_wstrb = 4'b1100; fmt_wdata = {es_rt_data[15:0], 16'b0}; end
                default: begin fmt_wstrb = 4'b1000; fmt_wdata = {es_rt_data[7:0], 24'b0}; end
            endcase
        end
`endif
        if (!fmt_wr) begin
            fmt_wstrb = 4'b0000;
            fmt_wdata = 32'h0;
        end
    end

    // FSM next state and EXE-side handshake
    always_comb begin
        state_d      = state_q;
        es_req_ready = 1'b0;
        load_req     = 1'b0;
        unique case (state_q)
            StIdle: begin
                es_req_ready = resetn && (out_q < MaxOut) && !flush;
                if (es_req_valid && es_req_ready && fmt_bus) begin
                    load_req = 1'b1;
                    state_d  = StReq;
                end
            end
            StReq: begin
                // Request is never withdrawn, not even on flush
                if (sram.data_sram_addr_ok) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outstanding and discard counter next state
    always_comb begin
        addr_hs   = (state_q == StReq) && sram.data_sram_addr_ok;
        rsp_hs    = sram.data_sram_data_ok && (out_q != 3'd0);
        out_d     = out_q + {2'b00, addr_hs} - {2'b00, rsp_hs};
        discard_d = discard_q;
        if (flush) begin
            // Everything still owed a response, including the held request
            discard_d = {1'b0, out_q} - {3'b000, rsp_hs} + {3'b000, state_q == StReq};
        end else if (sram.data_sram_data_ok && (discard_q != 4'd0)) begin
            discard_d = discard_q - 4'd1;
        end
    end

    // State, request fields and counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            wr_q      <= 1'b0;
            size_q    <= 2'd0;
            wstrb_q   <= 4'b0000;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            out_q     <= 3'd0;
            discard_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            discard_q <= discard_d;
            if (load_req) begin
                wr_q    <= fmt_wr;
                size_q  <= fmt_size;
                wstrb_q <= fmt_wstrb;
                addr_q  <= fmt_addr;
                wdata_q <= fmt_wdata;
            end
        end
    end

    assign sram.data_sram_req   = (state_q == StReq);
    assign sram.data_sram_wr    = wr_q;
    assign sram.data_sram_size  = size_q;
    assign sram.data_sram_wstrb = wstrb_q;
    assign sram.data_sram_addr  = addr_q;
    assign sram.data_sram_wdata = wdata_q;

    assign ms_rsp_valid = resetn && sram.data_sram_data_ok && (discard_q == 4'd0);
    assign outstanding  = out_q;

endmodule

// File: tb/tb_data_req_issuer.sv
// tb_data_req_issuer: directed vectors, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_data_req_issuer;

    localparam int Max = 2;
`ifdef UNALIGNED_STORE_EN
    localparam bit UaEn = 1'b1;
`else
    localparam bit UaEn = 1'b0;
`endif

    localparam int OpLb = 11, OpLbu = 10, OpLh = 9, OpLhu = 8, OpLw = 7;
    localparam int OpSb = 4, OpSh = 3, OpSw = 2, OpSwl = 1, OpSwr = 0, OpNone = -1;

    logic        clk = 1'b0;
    logic        resetn;
    logic        es_req_valid;
    logic        es_req_ready;
    logic [11:0] es_mem_op;
    logic [31:0] es_addr;
    logic [31:0] es_rt_data;
    logic        flush;
    logic        ms_rsp_valid;
    logic [2:0]  outstanding;

    data_req_issuer_if bus();

    data_req_issuer #(.MAX_OUTSTANDING(Max)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .es_req_valid (es_req_valid),
        .es_req_ready (es_req_ready),
        .es_mem_op    (es_mem_op),
        .es_addr      (es_addr),
        .es_rt_data   (es_rt_data),
        .flush        (flush),
        .sram         (bus),
        .ms_rsp_valid (ms_rsp_valid),
        .outstanding  (outstanding)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          bus;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          k;
        logic [31:0] addr;
        logic [31:0] rt;
        bit          exp_req;
        logic [1:0]  size;
        logic [31:0] eaddr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        bit          wr;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: one flag per in-flight transaction (1 = discard)
    bit   m_q[$];
    bit   m_pend;
    bit   m_flag;
    req_t m_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] op_of(input int k);
        logic [11:0] one;
        one = 12'd1;
        return (k >= 0 && k < 12) ? (one << k) : 12'd0;
    endfunction

    // Byte-lane arithmetic view of the formatting rules
    function automatic req_t ref_fmt(input int k, input logic [31:0] addr, input logic [31:0] rt);
        req_t r;
        int a;
        a = int'(addr[1:0]);
        r.bus   = (k >= 0) && (UaEn || !(k == OpSwl || k == OpSwr));
        r.wr    = (k >= 0) && (k <= OpSb);
        r.wstrb = 4'd0;
        r.wdata = 32'd0;
        if (k == OpLb || k == OpLbu || k == OpSb) begin
            r.size = 2'd0; r.addr = addr;
        end else if (k == OpLh || k == OpLhu || k == OpSh) begin
            r.size = 2'd1; r.addr = addr;
        end else begin
            r.size = 2'd2; r.addr = addr & 32'hFFFF_FFFC;
        end
        if (k == OpSb) begin
            r.wstrb = 4'(1 << a);
            r.wdata = {24'd0, rt[7:0]} * 32'h0101_0101;
        end else if (k == OpSh) begin
            r.wstrb = 4'(3 << (2 * (a / 2)));
            r.wdata = {16'd0, rt[15:0]} * 32'h0001_0001;
        end else if (k == OpSw) begin
            r.wstrb = 4'hF;
            r.wdata = rt;
        end else if (k == OpSwl) begin
            r.wstrb = 4'((1 << (a + 1)) - 1);
            r.wdata = rt >> (8 * (3 - a));
        end else if (k == OpSwr) begin
            r.wstrb = 4'((15 << a) & 15);
            r.wdata = rt << (8 * a);
        end
        return r;
    endfunction

    task automatic issue_lw(input logic [31:0] a);
        es_req_valid = 1'b1;
        es_mem_op    = op_of(OpLw);
        es_addr      = a;
        tick();
        es_req_valid = 1'b0;
        es_mem_op    = 12'd0;
        bus.data_sram_addr_ok = 1'b1;
        tick();
        bus.data_sram_addr_ok = 1'b0;
    endtask

    task automatic rsp(output logic ms);
        bus.data_sram_data_ok = 1'b1;
        #1;
        ms = ms_rsp_valid;
        tick();
        bus.data_sram_data_ok = 1'b0;
    endtask

    task automatic model_cycle(input bit v, input int k, input logic [31:0] a,
                               input logic [31:0] rt, input bit aok, input bit dok,
                               input bit fl);
        req_t nr;
        bit   exp_ready;
        bit   exp_ms;
        es_req_valid          = v;
        es_mem_op             = op_of(k);
        es_addr               = a;
        es_rt_data            = rt;
        bus.data_sram_addr_ok = aok;
        bus.data_sram_data_ok = dok;
        flush                 = fl;
        #1;
        exp_ready = !m_pend && (m_q.size() < Max) && !fl;
        exp_ms    = dok && (m_q.size() > 0) && !m_q[0];
        check("rnd req", 32'(bus.data_sram_req), 32'(m_pend));
        check("rnd ready", 32'(es_req_ready), 32'(exp_ready));
        check("rnd ms_rsp_valid", 32'(ms_rsp_valid), 32'(exp_ms));
        check("rnd outstanding", 32'(outstanding), 32'(m_q.size()));
        if (m_pend) begin
            check("rnd size", 32'(bus.data_sram_size), 32'(m_r.size));
            check("rnd addr", bus.data_sram_addr, m_r.addr);
            check("rnd wstrb", 32'(bus.data_sram_wstrb), 32'(m_r.wstrb));
            check("rnd wdata", bus.data_sram_wdata, m_r.wdata);
            check("rnd wr", 32'(bus.data_sram_wr), 32'(m_r.wr));
        end
        nr = ref_fmt(k, a, rt);
        if (dok && m_q.size() > 0) void'(m_q.pop_front());
        if (fl) begin
            foreach (m_q[i]) m_q[i] = 1'b1;
            if (m_pend) m_flag = 1'b1;
        end
        if (m_pend && aok) begin
            m_q.push_back(m_flag);
            m_pend = 1'b0;
        end
        if (v && exp_ready && nr.bus) begin
            m_pend = 1'b1;
            m_r    = nr;
            m_flag = 1'b0;
        end
        tick();
    endtask

    vec_t vecs[12];

    initial begin
        logic ms;
        int   k;
        vecs[0]  = '{OpSb,   32'h1003, 32'h1234_5678, 1'b1, 2'd0, 32'h1003, 4'h8, 32'h7878_7878, 1'b1};
        vecs[1]  = '{OpSwr,  32'h2002, 32'hAABB_CCDD, UaEn, 2'd2, 32'h2000, 4'hC, 32'hCCDD_0000, 1'b1};
        vecs[2]  = '{OpLw,   32'h3007, 32'hFFFF_FFFF, 1'b1, 2'd2, 32'h3004, 4'h0, 32'h0000_0000, 1'b0};
        vecs[3]  = '{OpSh,   32'h4002, 32'h1234_ABCD, 1'b1, 2'd1, 32'h4002, 4'hC, 32'hABCD_ABCD, 1'b1};
        vecs[4]  = '{OpSwl,  32'h5001, 32'h1122_3344, UaEn, 2'd2, 32'h5000, 4'h3, 32'h0000_1122, 1'b1};
        vecs[5]  = '{OpLbu,  32'h6002, 32'h0000_0000, 1'b1, 2'd0, 32'h6002, 4'h0, 32'h0000_0000, 1'b0};
        vecs[6]  = '{OpSw,   32'h7001, 32'hDEAD_BEEF, 1'b1, 2'd2, 32'h7000, 4'hF, 32'hDEAD_BEEF, 1'b1};
        vecs[7]  = '{OpNone, 32'h8000, 32'h0000_0001, 1'b0, 2'd0, 32'h0,     4'h0, 32'h0,         1'b0};
        vecs[8]  = '{OpLhu,  32'h8003, 32'h5555_5555, 1'b1, 2'd1, 32'h8003, 4'h0, 32'h0000_0000, 1'b0};
        vecs[9]  = '{OpSwl,  32'h9003, 32'hCAFE_F00D, UaEn, 2'd2, 32'h9000, 4'hF, 32'hCAFE_F00D, 1'b1};
        vecs[10] = '{OpSwr,  32'hA001, 32'h1122_3344, UaEn, 2'd2, 32'hA000, 4'hE, 32'h2233_4400, 1'b1};
        vecs[11] = '{OpSb,   32'hB000, 32'h0000_00A5, 1'b1, 2'd0, 32'hB000, 4'h1, 32'hA5A5_A5A5, 1'b1};

        // Reset state, with inputs trying to provoke activity
        resetn = 1'b0;
        es_req_valid = 1'b1;
        es_mem_op = op_of(OpLw);
        es_addr = 32'h1234;
        es_rt_data = 32'hFFFF_FFFF;
        flush = 1'b0;
        bus.data_sram_addr_ok = 1'b1;
        bus.data_sram_data_ok = 1'b1;
        #1;
        check("reset req", 32'(bus.data_sram_req), 32'd0);
        check("reset ready", 32'(es_req_ready), 32'd0);
        check("reset outstanding", 32'(outstanding), 32'd0);
        check("reset ms_rsp_valid", 32'(ms_rsp_valid), 32'd0);
        check("reset wr", 32'(bus.data_sram_wr), 32'd0);
        check("reset size", 32'(bus.data_sram_size), 32'd0);
        check("reset wstrb", 32'(bus.data_sram_wstrb), 32'd0);
        check("reset addr", bus.data_sram_addr, 32'd0);
        check("reset wdata", bus.data_sram_wdata, 32'd0);
        tick();
        es_req_valid = 1'b0;
        es_mem_op = 12'd0;
        bus.data_sram_addr_ok = 1'b0;
        bus.data_sram_data_ok = 1'b0;
        tick();
        resetn = 1'b1;
        tick();

        // Formatting vectors, each run as a full transaction
        for (int i = 0; i < 12; i++) begin
            es_mem_op = op_of(vecs[i].k);
            es_addr = vecs[i].addr;
            es_rt_data = vecs[i].rt;
            es_req_valid = 1'b1;
            #1;
            check("vec ready", 32'(es_req_ready), 32'd1);
            tick();
            es_req_valid = 1'b0;
            es_mem_op = 12'd0;
            check("vec req", 32'(bus.data_sram_req), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req) begin
                check("vec size", 32'(bus.data_sram_size), 32'(vecs[i].size));
                check("vec addr", bus.data_sram_addr, vecs[i].eaddr);
                check("vec wstrb", 32'(bus.data_sram_wstrb), 32'(vecs[i].wstrb));
                check("vec wdata", bus.data_sram_wdata, vecs[i].wdata);
                check("vec wr", 32'(bus.data_sram_wr), 32'(vecs[i].wr));
                bus.data_sram_addr_ok = 1'b1;
                tick();
                bus.data_sram_addr_ok = 1'b0;
                #1;
                check("vec req after addr_ok", 32'(bus.data_sram_req), 32'd0);
                check("vec outstanding 1", 32'(outstanding), 32'd1);
                rsp(ms);
                check("vec ms_rsp_valid", 32'(ms), 32'd1);
            end else begin
                tick();
                check("vec dropped req", 32'(bus.data_sram_req), 32'd0);
            end
            check("vec outstanding 0", 32'(outstanding), 32'd0);
        end

        // Back-to-back lw with immediate addr_ok, data_ok withheld
        bus.data_sram_addr_ok = 1'b1;
        es_req_valid = 1'b1;
        es_mem_op = op_of(OpLw);
        es_addr = 32'h100;
        #1;
        check("b2b ready first", 32'(es_req_ready), 32'd1);
        tick();
        check("b2b req first", 32'(bus.data_sram_req), 32'd1);
        check("b2b ready in REQ", 32'(es_req_ready), 32'd0);
        tick();
        check("b2b bubble req", 32'(bus.data_sram_req), 32'd0);
        check("b2b bubble ready", 32'(es_req_ready), 32'd1);
        check("b2b outstanding 1", 32'(outstanding), 32'd1);
        tick();
        check("b2b req second", 32'(bus.data_sram_req), 32'd1);
        tick();
        es_req_valid = 1'b0;
        es_mem_op = 12'd0;
        bus.data_sram_addr_ok = 1'b0;
        #1;
        check("b2b outstanding 2", 32'(outstanding), 32'd2);
        check("b2b ready full", 32'(es_req_ready), 32'd0);
        rsp(ms);
        check("b2b ms first", 32'(ms), 32'd1);
        #1;
        check("b2b outstanding after rsp", 32'(outstanding), 32'd1);
        check("b2b ready after rsp", 32'(es_req_ready), 32'd1);
        rsp(ms);
        check("b2b outstanding drained", 32'(outstanding), 32'd0);

        // Flush while a request waits for addr_ok
        es_req_valid = 1'b1;
        es_mem_op = op_of(OpLw);
        es_addr = 32'h200;
        tick();
        es_req_valid = 1'b0;
        es_mem_op = 12'd0;
        check("flushreq req", 32'(bus.data_sram_req), 32'd1);
        tick();
        flush = 1'b1;
        #1;
        check("flushreq ready", 32'(es_req_ready), 32'd0);
        check("flushreq req during flush", 32'(bus.data_sram_req), 32'd1);
        tick();
        flush = 1'b0;
        check("flushreq req held", 32'(bus.data_sram_req), 32'd1);
        check("flushreq addr held", bus.data_sram_addr, 32'h200);
        bus.data_sram_addr_ok = 1'b1;
        tick();
        bus.data_sram_addr_ok = 1'b0;
        check("flushreq outstanding", 32'(outstanding), 32'd1);
        rsp(ms);
        check("flushreq rsp discarded", 32'(ms), 32'd0);
        check("flushreq outstanding 0", 32'(outstanding), 32'd0);
        issue_lw(32'h204);
        rsp(ms);
        check("flushreq next rsp valid", 32'(ms), 32'd1);

        // Flush coincident with data_ok, two outstanding
        issue_lw(32'h300);
        issue_lw(32'h304);
        flush = 1'b1;
        bus.data_sram_data_ok = 1'b1;
        #1;
        check("flushrsp ms current", 32'(ms_rsp_valid), 32'd1);
        tick();
        flush = 1'b0;
        bus.data_sram_data_ok = 1'b0;
        check("flushrsp outstanding", 32'(outstanding), 32'd1);
        rsp(ms);
        check("flushrsp stale discarded", 32'(ms), 32'd0);
        check("flushrsp outstanding 0", 32'(outstanding), 32'd0);

        // Flush in IDLE blocks acceptance
        es_req_valid = 1'b1;
        es_mem_op = op_of(OpLw);
        flush = 1'b1;
        #1;
        check("idleflush ready", 32'(es_req_ready), 32'd0);
        tick();
        flush = 1'b0;
        es_req_valid = 1'b0;
        es_mem_op = 12'd0;
        check("idleflush no req", 32'(bus.data_sram_req), 32'd0);

        // Same-cycle addr_ok and data_ok with one outstanding
        issue_lw(32'h400);
        es_req_valid = 1'b1;
        es_mem_op = op_of(OpLw);
        tick();
        es_req_valid = 1'b0;
        es_mem_op = 12'd0;
        bus.data_sram_addr_ok = 1'b1;
        bus.data_sram_data_ok = 1'b1;
        #1;
        check("same ms", 32'(ms_rsp_valid), 32'd1);
        tick();
        bus.data_sram_addr_ok = 1'b0;
        bus.data_sram_data_ok = 1'b0;
        check("same outstanding", 32'(outstanding), 32'd1);
        rsp(ms);
        check("same drained", 32'(outstanding), 32'd0);

        // Async reset in REQ with one outstanding and a pending discard
        issue_lw(32'h500);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        es_req_valid = 1'b1;
        es_mem_op = op_of(OpLw);
        tick();
        es_req_valid = 1'b0;
        es_mem_op = 12'd0;
        check("areset pre req", 32'(bus.data_sram_req), 32'd1);
        check("areset pre outstanding", 32'(outstanding), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        check("areset req", 32'(bus.data_sram_req), 32'd0);
        check("areset outstanding", 32'(outstanding), 32'd0);
        check("areset ready", 32'(es_req_ready), 32'd0);
        tick();
        resetn = 1'b1;
        tick();
        issue_lw(32'h600);
        rsp(ms);
        check("areset discard cleared", 32'(ms), 32'd1);

        // Randomized run against the reference model from a clean reset
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        m_q.delete();
        m_pend = 1'b0;
        m_flag = 1'b0;
        tick();
        for (int n = 0; n < 3000; n++) begin
            k = int'($urandom_range(0, 12));
            if (k == 12) k = OpNone;
            model_cycle($urandom_range(0, 2) != 0, k, $urandom, $urandom,
                        $urandom_range(0, 1) == 1,
                        (m_q.size() > 0) && ($urandom_range(0, 2) == 0),
                        $urandom_range(0, 15) == 0);
        end
        for (int n = 0; n < 40 && (m_pend || m_q.size() > 0); n++) begin
            model_cycle(1'b0, OpNone, 32'd0, 32'd0, 1'b1, m_q.size() > 0, 1'b0);
        end
        check("drain req", 32'(bus.data_sram_req), 32'd0);
        check("drain outstanding", 32'(outstanding), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: run did not complete, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
